// File: rtl/key_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : key_step_ctrl
//  Description : Turns a debounced active-low key into one-cycle step strobes
//                for single-step CPU execution and keeps a wrapping count of
//                issued steps. Optional auto-repeat while the key is held is
//                built when KEY_AUTO_REPEAT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module key_step_ctrl #(
  parameter int HOLD_CYCLES   = 8,  // initial pulse to first repeat pulse (>=2)
  parameter int REPEAT_CYCLES = 4,  // spacing of repeat pulses (>=2)
  parameter int CNT_W         = 8   // width of press_count
) (
  input  logic             BJ_clk,
  input  logic             rst,
  input  logic             button_n,
  output logic             step_pulse,
  output logic             key_held,
  output logic [CNT_W-1:0] press_count
);

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_PRESS  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_REPEAT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  logic             r_step_pulse;
  logic             r_key_held;
  logic [CNT_W-1:0] r_press_count;

`ifdef KEY_AUTO_REPEAT_EN
  // Timer counts cycles since the most recent pulse; wide enough for either interval.
  localparam int              c_TW        = $clog2(HOLD_CYCLES + REPEAT_CYCLES) + 1;
  localparam logic [c_TW-1:0] c_TMR_ONE   = c_TW'(1);
  localparam logic [c_TW-1:0] c_HOLD_LAST = c_TW'(HOLD_CYCLES - 1);
  localparam logic [c_TW-1:0] c_REP_LAST  = c_TW'(REPEAT_CYCLES - 1);

  logic [c_TW-1:0] r_tmr;
`endif

  // Step controller: all outputs are registered and follow the state transitions.
  always_ff @(posedge BJ_clk) begin
    if (rst) begin
      r_state       <= ST_ARM;
      r_step_pulse  <= 1'b0;
      r_key_held    <= 1'b0;
      r_press_count <= '0;
`ifdef KEY_AUTO_REPEAT_EN
      r_tmr         <= '0;
`endif
    end else begin
      // A pulse lasts exactly one cycle unless a branch below re-asserts it.
      r_step_pulse <= 1'b0;
      case (r_state)
        // A key held through reset must be released before it can step.
        ST_ARM: begin
          r_key_held <= 1'b0;
          if (button_n) begin
            r_state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          r_key_held <= 1'b0;
          if (!button_n) begin
            r_state       <= ST_PRESS;
            r_step_pulse  <= 1'b1;
            r_press_count <= r_press_count + c_CNT_ONE;
`ifdef KEY_AUTO_REPEAT_EN
            r_tmr         <= '0;
`endif
          end
        end

        // Single cycle carrying the initial pulse.
        ST_PRESS: begin
          if (button_n) begin
            r_state    <= ST_IDLE;
            r_key_held <= 1'b0;
          end else begin
            r_state    <= ST_HOLD;
            r_key_held <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            r_tmr      <= r_tmr + c_TMR_ONE;
`endif
          end
        end

        // Release wins over a pulse that would be due on the same edge.
        ST_HOLD: begin
          if (button_n) begin
            r_state    <= ST_IDLE;
            r_key_held <= 1'b0;
          end
`ifdef KEY_AUTO_REPEAT_EN
          else if (r_tmr == c_HOLD_LAST) begin
            r_state       <= ST_REPEAT;
            r_step_pulse  <= 1'b1;
            r_press_count <= r_press_count + c_CNT_ONE;
            r_tmr         <= '0;
          end else begin
            r_tmr <= r_tmr + c_TMR_ONE;
          end
`endif
        end

`ifdef KEY_AUTO_REPEAT_EN
        ST_REPEAT: begin
          if (button_n) begin
            r_state    <= ST_IDLE;
            r_key_held <= 1'b0;
          end else if (r_tmr == c_REP_LAST) begin
            r_step_pulse  <= 1'b1;
            r_press_count <= r_press_count + c_CNT_ONE;
            r_tmr         <= '0;
          end else begin
            r_tmr <= r_tmr + c_TMR_ONE;
          end
        end
`endif

        // Unreachable encodings recover through ARM so no spurious step is issued.
        default: begin
          r_state    <= ST_ARM;
          r_key_held <= 1'b0;
        end
      endcase
    end
  end

  assign step_pulse  = r_step_pulse;
  assign key_held    = r_key_held;
  assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_key_step_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_step_ctrl
//  Description : Self-checking bench for key_step_ctrl. Directed scenarios plus
//                random key activity, compared cycle by cycle against a
//                behavioural model built on time-since-press arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_step_ctrl;

  localparam int HOLD_CYCLES   = 8;
  localparam int REPEAT_CYCLES = 4;
  localparam int CNT_W         = 4;
`ifdef KEY_AUTO_REPEAT_EN
  localparam bit AUTO_EN = 1'b1;
`else
  localparam bit AUTO_EN = 1'b0;
`endif

  logic             BJ_clk   = 1'b0;
  logic             rst      = 1'b1;
  logic             button_n = 1'b1;
  logic             step_pulse;
  logic             key_held;
  logic [CNT_W-1:0] press_count;

  int n_cmp   = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int n_pulse = 0;
  bit held_seen  = 1'b0;
  bit prev_pulse = 1'b0;
  int q_pulse[$];

  // Reference model state: armed = a release has been seen since reset,
  // pressing = key currently down after an accepted press, age = cycles since
  // the initial pulse of that press.
  bit m_armed    = 1'b0;
  bit m_pressing = 1'b0;
  int m_age      = 0;
  bit m_pulse    = 1'b0;
  bit m_held     = 1'b0;
  int m_count    = 0;

  always #5 BJ_clk = ~BJ_clk;

  key_step_ctrl #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .BJ_clk     (BJ_clk),
    .rst        (rst),
    .button_n   (button_n),
    .step_pulse (step_pulse),
    .key_held   (key_held),
    .press_count(press_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input bit r, input bit b);
    if (r) begin
      m_armed = 1'b0; m_pressing = 1'b0; m_age = 0;
      m_pulse = 1'b0; m_held = 1'b0; m_count = 0;
    end else if (!m_armed) begin
      m_pulse = 1'b0; m_held = 1'b0;
      if (b) m_armed = 1'b1;
    end else if (b) begin
      m_pressing = 1'b0; m_pulse = 1'b0; m_held = 1'b0;
    end else if (!m_pressing) begin
      m_pressing = 1'b1; m_age = 0; m_pulse = 1'b1; m_held = 1'b0;
      m_count = (m_count + 1) % (1 << CNT_W);
    end else begin
      m_age++;
      m_held  = 1'b1;
      m_pulse = AUTO_EN && (m_age >= HOLD_CYCLES) &&
                (((m_age - HOLD_CYCLES) % REPEAT_CYCLES) == 0);
      if (m_pulse) m_count = (m_count + 1) % (1 << CNT_W);
    end
  endtask

  // Drive one clock's inputs, advance the model on the edge, check after it.
  task automatic step(input int r, input int b);
    rst      = 1'(r);
    button_n = 1'(b);
    @(posedge BJ_clk);
    model_edge(1'(r), 1'(b));
    #1;
    cyc++;
    check("model_step_pulse", 32'(step_pulse), 32'(m_pulse));
    check("model_key_held", 32'(key_held), 32'(m_held));
    check("model_press_count", 32'(press_count), 32'(m_count));
    check("no_back_to_back", 32'(step_pulse & prev_pulse), 0);
    prev_pulse = step_pulse;
    if (step_pulse === 1'b1) begin
      n_pulse++;
      q_pulse.push_back(cyc);
    end
    if (key_held === 1'b1) held_seen = 1'b1;
  endtask

  initial begin
    int base;
    int k;
    int len;
    int bv;
    int rv;
    int exp_off[7];
    exp_off = '{0, 8, 12, 16, 20, 24, 28};

    // 1: key held through reset never steps until released
    repeat (3) step(1, 0);
    check("reset_step_pulse", 32'(step_pulse), 0);
    check("reset_key_held", 32'(key_held), 0);
    check("reset_press_count", 32'(press_count), 0);
    base = n_pulse;
    repeat (20) step(0, 0);
    check("t1_no_pulse_while_armed", n_pulse - base, 0);
    check("t1_count_zero", 32'(press_count), 0);
    step(0, 1); step(0, 0); step(0, 1);
    check("t1_one_pulse", n_pulse - base, 1);
    check("t1_count_one", 32'(press_count), 1);

    // 2: basic press timing and key_held window
    step(0, 1);
    base = n_pulse;
    k = int'(press_count);
    step(0, 0);
    check("t2_pulse_first_cycle", 32'(step_pulse), 1);
    check("t2_held_low_first", 32'(key_held), 0);
    step(0, 0);
    check("t2_pulse_cleared", 32'(step_pulse), 0);
    check("t2_held_set", 32'(key_held), 1);
    repeat (3) step(0, 0);
    check("t2_held_still", 32'(key_held), 1);
    step(0, 1);
    check("t2_held_cleared", 32'(key_held), 0);
    check("t2_single_pulse", n_pulse - base, 1);
    check("t2_count_inc", 32'(press_count), (k + 1) % 16);

    // 3: long hold, auto-repeat schedule
    step(0, 1);
    q_pulse.delete();
    k = int'(press_count);
    repeat (30) step(0, 0);
    step(0, 1);
    check("t3_pulse_total", q_pulse.size(), AUTO_EN ? 7 : 1);
    check("t3_count", 32'(press_count), (k + (AUTO_EN ? 7 : 1)) % 16);
    for (int i = 1; i < q_pulse.size() && i < 7; i++)
      check("t3_pulse_offset", q_pulse[i] - q_pulse[0], exp_off[i]);

    // 4: seventeen presses wrap the 4-bit count
    step(1, 1);
    step(0, 1);
    check("t4_count_cleared", 32'(press_count), 0);
    for (int i = 1; i <= 17; i++) begin
      step(0, 0);
      check("t4_count_seq", 32'(press_count), i % 16);
      step(0, 1);
    end

    // 5: reset while held deep in the press (REPEAT when auto-repeat is built)
    step(0, 1);
    repeat (10) step(0, 0);
    step(1, 0);
    check("t5_rst_pulse", 32'(step_pulse), 0);
    check("t5_rst_held", 32'(key_held), 0);
    check("t5_rst_count", 32'(press_count), 0);
    base = n_pulse;
    repeat (5) step(0, 0);
    check("t5_no_pulse_after_rst", n_pulse - base, 0);
    step(0, 1);
    step(0, 0);
    check("t5_pulse_after_release", 32'(step_pulse), 1);
    check("t5_one_pulse", n_pulse - base, 1);
    step(0, 1);

    // 6: minimal press / release / press
    step(0, 1);
    base = n_pulse;
    k = int'(press_count);
    held_seen = 1'b0;
    step(0, 0); step(0, 1); step(0, 0); step(0, 1);
    check("t6_two_pulses", n_pulse - base, 2);
    check("t6_count", 32'(press_count), (k + 2) % 16);
    check("t6_never_held", 32'(held_seen), 0);

    // Random key activity with occasional resets
    for (int r = 0; r < 80; r++) begin
      len = int'($urandom_range(1, 14));
      bv  = int'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 19) == 0) ? 1 : 0;
      for (int j = 0; j < len; j++) step((j == 0) ? rv : 0, bv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
